// File: rtl/seq_data_compare.sv
// seq_data_compare: multi-cycle magnitude comparator for WIDTH*WORDS-bit operands
// that arrive as WORDS slices of WIDTH bits each, MSB slice first.
//
// Ports:
//   iClk     - clock, rising edge
//   iRst_n   - asynchronous active-low reset
//   iStart   - begin a compare (sampled in IDLE only)
//   iSigned  - latched with iStart: 1 = two's complement, 0 = unsigned
//   iValid   - slice on iData_a/iData_b is valid
//   iData_a  - operand A slice
//   iData_b  - operand B slice
//   oReady   - a slice is accepted this cycle when iValid is high (RUN)
//   oBusy    - compare in progress (RUN or DONE)
//   oDone    - one-cycle pulse, oData is final
//   oData    - {A>B, A==B, A<B}, held until the next completed compare
module seq_data_compare #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic             iValid,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    output logic             oReady,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          signed_mode;
    logic          decided;
    logic          dec_gt;

    logic          accept_c;
    logic          last_c;
    logic          slice_gt_c;
    logic          slice_lt_c;
    logic [2:0]    result_c;

    // Per-slice compare; only the MSB slice carries the sign in signed mode.
    always_comb begin
        accept_c   = 1'b0;
        last_c     = 1'b0;
        slice_gt_c = 1'b0;
        slice_lt_c = 1'b0;
        result_c   = RES_EQ;

        accept_c = (state == RUN) && iValid && oReady;
        last_c   = (cnt == LAST_IDX);

        if (signed_mode && (cnt == '0)) begin
            slice_gt_c = $signed(iData_a) > $signed(iData_b);
            slice_lt_c = $signed(iData_a) < $signed(iData_b);
        end else begin
            slice_gt_c = iData_a > iData_b;
            slice_lt_c = iData_a < iData_b;
        end

        // An earlier decision wins; otherwise the current slice decides.
        if (decided) begin
            result_c = dec_gt ? RES_GT : RES_LT;
        end else if (slice_gt_c) begin
            result_c = RES_GT;
        end else if (slice_lt_c) begin
            result_c = RES_LT;
        end else begin
            result_c = RES_EQ;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            signed_mode <= 1'b0;
            decided     <= 1'b0;
            dec_gt      <= 1'b0;
            oReady      <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oData       <= 3'b000;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        signed_mode <= iSigned;
                        cnt         <= '0;
                        decided     <= 1'b0;
                        dec_gt      <= 1'b0;
                        oReady      <= 1'b1;
                        oBusy       <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        if (!decided && (slice_gt_c || slice_lt_c)) begin
                            decided <= 1'b1;
                            dec_gt  <= slice_gt_c;
                        end
                        if (last_c) begin
                            oData  <= result_c;
                            oDone  <= 1'b1;
                            oReady <= 1'b0;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oReady <= 1'b0;
                    oBusy  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_data_compare.sv
// Testbench for seq_data_compare: directed cases plus randomized compares
// checked against a whole-operand magnitude model.
module tb_seq_data_compare;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned TW    = WIDTH * WORDS;

    logic             iClk;
    logic             iRst_n;
    logic             iStart;
    logic             iSigned;
    logic             iValid;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             oReady;
    logic             oBusy;
    logic             oDone;
    logic [2:0]       oData;

    int checks;
    int errors;
    int done_count;
    logic [2:0] last_result;

    seq_data_compare #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iValid  (iValid),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .oReady  (oReady),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Count done pulses, sampled away from the active edge.
    always @(negedge iClk) begin
        if (oDone === 1'b1) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: compare the full operands as integers.
    function automatic logic [2:0] ref_cmp(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                           input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b001;
            return 3'b010;
        end
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        return 3'b010;
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [TW-1:0] v, input int idx);
        return v[(WORDS-1-idx)*WIDTH +: WIDTH];
    endfunction

    // One full compare. Inputs driven and outputs sampled on the falling edge.
    // max_gap: random idle cycles before each slice; poke_start: pulse iStart in gaps.
    task automatic do_compare(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                              input int max_gap, input bit poke_start, input string tag);
        logic [2:0] exp;
        int dc0;
        exp = ref_cmp(a, b, s);
        dc0 = done_count;
        @(negedge iClk);
        iStart  = 1'b1;
        iSigned = s;
        iValid  = 1'b1;                  // must be ignored alongside iStart
        iData_a = WIDTH'($urandom);
        iData_b = WIDTH'($urandom);
        @(negedge iClk);
        iStart = 1'b0;
        iValid = 1'b0;
        iSigned = ~s;                    // mode must already be latched
        check({tag, " run_ready"}, 32'(oReady), 32'd1);
        check({tag, " run_busy"}, 32'(oBusy), 32'd1);
        check({tag, " data_hold"}, 32'(oData), 32'(last_result));
        for (int i = 0; i < int'(WORDS); i++) begin
            int gaps;
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                iValid = 1'b0;
                iStart = poke_start;
                iData_a = WIDTH'($urandom);
                iData_b = WIDTH'($urandom);
                @(negedge iClk);
            end
            iStart  = 1'b0;
            iValid  = 1'b1;
            iData_a = slice_of(a, i);
            iData_b = slice_of(b, i);
            check({tag, " no_early_done"}, 32'(oDone), 32'd0);
            @(negedge iClk);
        end
        iValid = 1'b0;
        check({tag, " done"}, 32'(oDone), 32'd1);
        check({tag, " result"}, 32'(oData), 32'(exp));
        check({tag, " done_ready"}, 32'(oReady), 32'd0);
        check({tag, " done_busy"}, 32'(oBusy), 32'd1);
        last_result = exp;
        @(negedge iClk);
        check({tag, " idle_busy"}, 32'(oBusy), 32'd0);
        check({tag, " idle_done"}, 32'(oDone), 32'd0);
        check({tag, " one_done"}, 32'(done_count - dc0), 32'd1);
    endtask

    initial begin
        logic [TW-1:0] ra;
        logic [TW-1:0] rb;
        int dc0;
        checks = 0;
        errors = 0;
        done_count = 0;
        last_result = 3'b000;
        iRst_n  = 1'b0;
        iStart  = 1'b0;
        iSigned = 1'b0;
        iValid  = 1'b0;
        iData_a = '0;
        iData_b = '0;

        // Reset and idle behaviour
        repeat (3) @(negedge iClk);
        check("rst_data", 32'(oData), 32'd0);
        check("rst_ready", 32'(oReady), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        iRst_n = 1'b1;
        iValid = 1'b1;
        iData_a = 8'h55;
        iData_b = 8'h11;
        repeat (5) @(negedge iClk);
        check("idle_ready", 32'(oReady), 32'd0);
        check("idle_busy", 32'(oBusy), 32'd0);
        check("idle_data", 32'(oData), 32'd0);
        check("idle_no_done", 32'(done_count), 32'd0);
        iValid = 1'b0;

        // Directed cases
        do_compare(32'h0808F0FF, 32'h0808F0FF, 1'b0, 0, 1'b0, "eq_u");
        check("eq_u_val", 32'(oData), 32'h2);
        do_compare(32'h08000000, 32'h00FFFFFF, 1'b0, 0, 1'b0, "early_u");
        check("early_u_val", 32'(oData), 32'h4);
        do_compare(32'hF0000000, 32'h0F000000, 1'b1, 0, 1'b0, "sgn_s");
        check("sgn_s_val", 32'(oData), 32'h1);
        do_compare(32'hF0000000, 32'h0F000000, 1'b0, 0, 1'b0, "sgn_u");
        check("sgn_u_val", 32'(oData), 32'h4);
        do_compare(32'h00000001, 32'h00000002, 1'b0, 2, 1'b1, "gaps");
        check("gaps_val", 32'(oData), 32'h1);
        // Lower slice sign bits must not be treated as signed
        do_compare(32'h01800000, 32'h017F0000, 1'b1, 1, 1'b0, "low_unsigned");
        check("low_unsigned_val", 32'(oData), 32'h4);

        // Reset mid-operation after two accepted slices
        dc0 = done_count;
        @(negedge iClk);
        iStart = 1'b1;
        iSigned = 1'b0;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iValid = 1'b1;
            iData_a = 8'h12;
            iData_b = 8'h34;
            @(negedge iClk);
        end
        iValid = 1'b0;
        #2 iRst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(oData), 32'd0);
        check("mid_rst_ready", 32'(oReady), 32'd0);
        check("mid_rst_busy", 32'(oBusy), 32'd0);
        check("mid_rst_done", 32'(oDone), 32'd0);
        last_result = 3'b000;
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (4) @(negedge iClk);
        check("mid_rst_no_done", 32'(done_count - dc0), 32'd0);
        do_compare(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0, "post_rst");
        check("post_rst_val", 32'(oData), 32'h2);

        // Randomized compares, biased toward shared upper slices
        for (int n = 0; n < 60; n++) begin
            ra = TW'($urandom);
            rb = TW'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[TW-1 -: WIDTH], rb[TW-WIDTH-1:0]};
                2: rb = {ra[TW-1 -: 2*WIDTH], rb[TW-2*WIDTH-1:0]};
                default: ;
            endcase
            do_compare(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
